// File: rtl/clock_pkg.sv
// Shared types and limits for the timekeeping path. The keypad entry controller
// imports this package for the same range checks.
package clock_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, DONE} alarm_state_t;

  function automatic logic time_valid(input logic [HOUR_W-1:0] h, input logic [MIN_W-1:0] m);
    return (h <= MAX_HOUR) && (m <= MAX_MIN);
  endfunction

endpackage

// File: rtl/clock_core_if.sv
// Bundle between the keypad entry controller (master) and clock_core (slave),
// carrying the time load, the alarm setting and the running-time outputs.
interface clock_core_if;
  import clock_pkg::*;

  logic              set;
  logic [HOUR_W-1:0] nowH;
  logic [MIN_W-1:0]  nowM;
  logic [HOUR_W-1:0] timerH;
  logic [MIN_W-1:0]  timerM;
  logic              run_enable;
  logic [HOUR_W-1:0] curH;
  logic [MIN_W-1:0]  curM;
  logic [SEC_W-1:0]  curS;
  logic              sec_tick;
  logic              alarm;
  logic              ringing;

  modport master (
    output set, nowH, nowM, timerH, timerM, run_enable,
    input  curH, curM, curS, sec_tick, alarm, ringing
  );

  modport slave (
    input  set, nowH, nowM, timerH, timerM, run_enable,
    output curH, curM, curS, sec_tick, alarm, ringing
  );

endinterface

// File: rtl/sec_prescaler.sv
// Divides mclk down to one pulse per second. tick flags the terminal-count cycle,
// so the consumer registers it alongside the time increment.
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic mclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge mclk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LastCnt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // A same-cycle load restarts the second, so the wrap is dropped.
  assign tick = (cnt_q == LastCnt) && !clear;

endmodule

// File: rtl/clock_core.sv
// 24-hour HH:MM:SS clock with a one-shot alarm FSM (IDLE/ARMED/RINGING/DONE).
// Define ALARM_BLINK_EN to make alarm toggle each second while ringing.
module clock_core
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned RING_SECS     = 30
) (
  input  logic         mclk,
  input  logic         reset,
  clock_core_if.slave  bus
);

  localparam logic [7:0] RingLast = 8'(RING_SECS - 1);

  logic              load;
  logic              tick;
  logic              match;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              sec_tick_q;
  alarm_state_t      state_q;
  logic [7:0]        ring_cnt_q;
  logic              alarm_q;
  logic              ringing_q;

  assign load = bus.set && time_valid(bus.nowH, bus.nowM);

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .mclk (mclk),
    .reset(reset),
    .clear(load),
    .tick (tick)
  );

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (load) begin
      hour_d = bus.nowH;
      min_d  = bus.nowM;
      sec_d  = '0;
    end else if (tick) begin
      if (sec_q == MAX_SEC) begin
        sec_d = '0;
        if (min_q == MAX_MIN) begin
          min_d  = '0;
          hour_d = (hour_q == MAX_HOUR) ? '0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Only a tick rolling into the timer minute counts; out-of-range timers never equal.
  assign match = tick && (sec_d == '0) && (hour_d == bus.timerH) && (min_d == bus.timerM);

  always_ff @(posedge mclk) begin
    if (reset) begin
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= tick;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset || !bus.run_enable) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      alarm_q    <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= ARMED;
        ARMED: begin
          if (match) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
            alarm_q    <= 1'b1;
            ringing_q  <= 1'b1;
          end
        end
        RINGING: begin
          if (tick) begin
            ring_cnt_q <= ring_cnt_q + 8'd1;
            if (ring_cnt_q == RingLast) begin
              state_q   <= DONE;
              alarm_q   <= 1'b0;
              ringing_q <= 1'b0;
            end else begin
`ifdef ALARM_BLINK_EN
              alarm_q <= ~alarm_q;
`else
              alarm_q <= 1'b1;
`endif
            end
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.curH     = hour_q;
  assign bus.curM     = min_q;
  assign bus.curS     = sec_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.alarm    = alarm_q;
  assign bus.ringing  = ringing_q;

endmodule

// File: tb/tb_clock_core.sv
// Bench for clock_core: directed scenarios plus random set/arm/timer traffic,
// all checked every cycle against a seconds-of-day reference model.
module tb_clock_core;

  localparam int TPS  = 4;
  localparam int RING = 3;

  logic mclk;
  logic reset;
  clock_core_if bus();

  clock_core #(
    .TICKS_PER_SEC(TPS),
    .RING_SECS    (RING)
  ) dut (
    .mclk (mclk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, alarm as mode + elapsed ring seconds.
  int m_tod = 0;
  int m_pre = 0;
  int m_mode = 0;      // 0 idle, 1 armed, 2 ringing, 3 done
  int m_elapsed = 0;
  bit m_tick = 0;
  bit m_valid = 0;

  task automatic model_step();
    int nh, nm, th, tm;
    bit ld, tk, hit;
    if (reset) begin
      m_tod = 0; m_pre = 0; m_mode = 0; m_elapsed = 0; m_tick = 0; m_valid = 1;
      return;
    end
    nh = int'(bus.nowH); nm = int'(bus.nowM);
    th = int'(bus.timerH); tm = int'(bus.timerM);
    ld = bus.set && nh <= 23 && nm <= 59;
    tk = 0;
    if (ld) begin
      m_tod = nh * 3600 + nm * 60;
      m_pre = 0;
    end else if (m_pre == TPS - 1) begin
      m_pre = 0;
      m_tod = (m_tod + 1) % 86400;
      tk = 1;
    end else begin
      m_pre++;
    end
    m_tick = tk;
    hit = tk && th <= 23 && tm <= 59 && m_tod == th * 3600 + tm * 60;
    if (!bus.run_enable) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && hit) begin
      m_mode = 2;
      m_elapsed = 0;
    end else if (m_mode == 2 && tk) begin
      m_elapsed++;
      if (m_elapsed == RING) m_mode = 3;
    end
  endtask

  function automatic bit exp_alarm();
    if (m_mode != 2) return 1'b0;
`ifdef ALARM_BLINK_EN
    return (m_elapsed % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial forever begin
    @(posedge mclk);
    model_step();
  end

  initial forever begin
    @(negedge mclk);
    if (m_valid) begin
      check("curH", 32'(bus.curH), 32'(m_tod / 3600));
      check("curM", 32'(bus.curM), 32'((m_tod / 60) % 60));
      check("curS", 32'(bus.curS), 32'(m_tod % 60));
      check("sec_tick", 32'(bus.sec_tick), 32'(m_tick));
      check("alarm", 32'(bus.alarm), 32'(exp_alarm()));
      check("ringing", 32'(bus.ringing), 32'(m_mode == 2));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic load_time(input int h, input int m);
    bus.set = 1'b1;
    bus.nowH = 5'(h);
    bus.nowM = 6'(m);
    cyc();
    bus.set = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.set = 1'b0;
    bus.nowH = '0;
    bus.nowM = '0;
    bus.timerH = 5'd7;
    bus.timerM = 6'd30;
    bus.run_enable = 1'b0;
    cyc(2);
    check("rst_curH", 32'(bus.curH), 0);
    check("rst_curS", 32'(bus.curS), 0);
    check("rst_alarm", 32'(bus.alarm), 0);
    check("rst_ringing", 32'(bus.ringing), 0);
    reset = 1'b0;

    cyc(3);
    check("no_tick_yet", 32'(bus.sec_tick), 0);
    cyc();
    check("first_sec", 32'(bus.curS), 1);
    check("first_tick", 32'(bus.sec_tick), 1);
    cyc(236);
    check("one_min_M", 32'(bus.curM), 1);
    check("one_min_S", 32'(bus.curS), 0);

    load_time(23, 59);
    check("load_H", 32'(bus.curH), 23);
    check("load_S", 32'(bus.curS), 0);
    cyc(236);
    check("pre_wrap_S", 32'(bus.curS), 59);
    cyc(4);
    check("wrap_H", 32'(bus.curH), 0);
    check("wrap_M", 32'(bus.curM), 0);
    check("wrap_S", 32'(bus.curS), 0);

    load_time(24, 10);
    check("bad_hour_H", 32'(bus.curH), 0);
    check("bad_hour_M", 32'(bus.curM), 0);
    load_time(12, 60);
    check("bad_min_H", 32'(bus.curH), 0);

    bus.run_enable = 1'b1;
    load_time(7, 29);
    cyc(239);
    check("pre_ring_S", 32'(bus.curS), 59);
    check("pre_ring", 32'(bus.ringing), 0);
    cyc();
    check("ring_M", 32'(bus.curM), 30);
    check("ring_on", 32'(bus.ringing), 1);
    check("alarm_s0", 32'(bus.alarm), 1);
    cyc(4);
`ifdef ALARM_BLINK_EN
    check("alarm_s1", 32'(bus.alarm), 0);
`else
    check("alarm_s1", 32'(bus.alarm), 1);
`endif
    cyc(4);
    check("alarm_s2", 32'(bus.alarm), 1);
    cyc(4);
    check("ring_off", 32'(bus.ringing), 0);
    check("alarm_off", 32'(bus.alarm), 0);
    load_time(7, 29);
    cyc(240);
    check("done_no_retrigger", 32'(bus.ringing), 0);

    bus.run_enable = 1'b0;
    cyc();
    bus.run_enable = 1'b1;
    load_time(7, 29);
    cyc(241);
    check("rearm_ring", 32'(bus.ringing), 1);
    bus.run_enable = 1'b0;
    cyc();
    check("disarm_ringing", 32'(bus.ringing), 0);
    check("disarm_alarm", 32'(bus.alarm), 0);
    bus.run_enable = 1'b1;
    cyc();
    load_time(7, 30);
    cyc(8);
    check("set_eq_timer", 32'(bus.ringing), 0);

    for (int i = 0; i < 5000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      reset = (r < 2);
      bus.set = 1'b0;
      if (r >= 2 && r < 30) begin
        bus.set = 1'b1;
        if (r < 20 && bus.timerM > 0 && bus.timerM <= 59) begin
          bus.nowH = bus.timerH;
          bus.nowM = bus.timerM - 6'd1;
        end else begin
          bus.nowH = 5'($urandom_range(0, 25));
          bus.nowM = 6'($urandom_range(0, 62));
        end
      end
      if (r >= 30 && r < 34) bus.run_enable = ~bus.run_enable;
      if (r >= 34 && r < 40) begin
        bus.timerH = 5'($urandom_range(0, 24));
        bus.timerM = 6'($urandom_range(0, 61));
      end
      cyc();
    end
    reset = 1'b0;
    bus.set = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
